dmem_store_sequencer: RTL and testbench
=======================================

# dmem_store_sequencer

Sequences every store from the MEM stage into the 64-bit-wide data memory write port, so unaligned stores never reach the port as a silent no-op. Accepts one store at a time on a valid/ready handshake and issues it as one aligned doubleword write, or two when the access straddles a doubleword line. Each beat carries the correct byte-enable mask and lane-shifted data. Sits between the MEM pipeline stage and the dmem write port; `req_ready` low stalls the pipeline.

## Interface
- `LINE_AW`, 13: width of the doubleword line address, taken from byte address bits [LINE_AW+2:3].
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  a store is presented.
- `req_ready`  out  1  the sequencer accepts the store this cycle.
- `req_func3`  in  3  RISC-V store funct3: 000 sb, 001 sh, 010 sw, 011 sd.
- `req_addr`  in  64  store byte address.
- `req_data`  in  64  store data, right-justified.
- `mem_wr_valid`  out  1  a write beat is presented to dmem.
- `mem_gnt`  in  1  dmem accepts the current beat.
- `mem_addr`  out  LINE_AW  doubleword line address of the beat.
- `mem_be`  out  8  byte enables of the beat.
- `mem_wdata`  out  64  lane-aligned write data of the beat.
- `done`  out  1  one-cycle pulse: the store has fully retired.
- `err`  out  1  one-cycle pulse: illegal funct3; nothing was written.

## Operation
- States: IDLE, BEAT0, BEAT1, RETIRE.
- `req_ready` = 1 only in IDLE and RETIRE.
- Acceptance is `req_valid & req_ready`. On acceptance, register:
  - offset o = addr[2:0];
  - line L = addr[LINE_AW+2:3];
  - 16-bit mask M = ((1<<size)-1) << o, where size = 1<<func3[1:0];
  - 128-bit data D = {64'b0, data} << (8*o).
- Legal funct3 is func3[2] = 0.
  - Legal: next state is BEAT0.
  - Illegal: next state is RETIRE with `err` set; no beat is issued.
- BEAT0 drives `mem_wr_valid`=1, `mem_addr`=L, `mem_be`=M[7:0], `mem_wdata`=D[63:0].
- BEAT1 drives `mem_addr`=L+1 (mod 2^LINE_AW, so line 0x1FFF wraps to 0x0000), `mem_be`=M[15:8], `mem_wdata`=D[127:64].
- Transitions:
  - BEAT0 with `mem_gnt`: go to BEAT1 if M[15:8]≠0, else RETIRE.
  - BEAT1 with `mem_gnt`: go to RETIRE.
  - Without `mem_gnt`, the state and all beat outputs hold stable.
- RETIRE asserts `done` (or `err`) for exactly one cycle. It returns to IDLE, or goes straight to BEAT0/RETIRE if a new request is accepted in the same cycle.
- Outside BEAT0/BEAT1: `mem_wr_valid`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0.
- Aligned sh/sw/sd and any access that does not cross a line complete in a single beat.
- Reset, including mid-store:
  - state returns to IDLE;
  - all outputs are 0 except `req_ready`=1;
  - any pending BEAT1 is dropped, with no partial retry.

## Timing
- Request accepted at edge N: BEAT0 is visible in cycle N+1.
- With `mem_gnt` held high:
  - single-beat store: `done` in N+2;
  - two-beat store: BEAT1 in N+2, `done` in N+3.
- Each cycle `mem_gnt` is low in a beat state adds one cycle.
- Back-to-back throughput: one single-beat store every 2 cycles, because RETIRE accepts the next request.
- Illegal funct3 accepted at N: `err` in N+1, with no `mem_wr_valid`.
- All outputs are registered or decoded from registered state only. There is no combinational path from `req_*` or `mem_gnt` to any output except `req_ready` (state only).

## Structure
- Shared package `dmem_pkg`:
  - store funct3 constants SB/SH/SW/SD;
  - state enum;
  - `LINE_AW` default.
- One natural sub-module, `store_lane_gen`: combinational. Inputs are func3, offset and data; outputs are the 16-bit mask M and the 128-bit shifted data D. It is instantiated on the request side so its outputs are registered at acceptance.

## Test plan
- sd at 0x0000_0040, data 0x1122334455667788, `mem_gnt`=1 → one beat: line 0x008, be 0xFF, wdata unchanged; `done` at N+2.
- sw at 0x...0046, data 0xAABBCCDD, `mem_gnt`=1 → beat0: line 0x008, be 0xC0, wdata[63:48]=0xCCDD. Beat1: line 0x009, be 0x03, wdata[15:0]=0xAABB. `done` at N+3.
- sh at 0x...FFFF (line 0x1FFF), data 0xBEEF → beat0: line 0x1FFF, be 0x80, byte 0xEF. Beat1: line 0x0000, be 0x01, byte 0xBE.
- sb at 0x...0003 with `mem_gnt` low for 3 cycles → `mem_wr_valid`, be 0x08 and data held stable for 4 cycles; `req_ready`=0 throughout; `done` follows the grant.
- funct3=100 → `err` pulse at N+1, no `mem_wr_valid`, `done` stays 0; the next legal store is accepted in the RETIRE cycle.
- `rst_n` asserted during BEAT0 of a line-crossing sw → outputs zero immediately (async). After release: `req_ready`=1, no BEAT1, no `done`.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared store funct3 codes, sequencer state encoding and default line width.
package dmem_pkg;
    localparam int LINE_AW_DEFAULT = 13;
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;
    typedef enum logic [1:0] {
        IDLE,
        BEAT0,
        BEAT1,
        RETIRE
    } state_t;
endpackage

// File: rtl/dmem_store_sequencer_store_lane_gen.sv
// store_lane_gen: 16-bit byte mask and 128-bit lane-shifted data of a store across two doubleword lines.
module store_lane_gen (
    input  logic [2:0]   func3,
    input  logic [2:0]   offset,
    input  logic [63:0]  data,
    output logic [15:0]  mask,
    output logic [127:0] shifted
);
    logic [3:0]  size;
    logic [15:0] base;
    logic        unused;
    assign unused  = func3[2];
    assign size    = 4'd1 << func3[1:0];
    assign base    = (16'd1 << size) - 16'd1;
    assign mask    = base << offset;
    assign shifted = {64'b0, data} << {offset, 3'b000};
endmodule

// File: rtl/dmem_store_sequencer.sv
// dmem_store_sequencer: splits each MEM-stage store into one or two aligned doubleword write beats.
module dmem_store_sequencer
    import dmem_pkg::*;
#(
    parameter int LINE_AW = LINE_AW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_func3,
    input  logic [63:0]        req_addr,
    input  logic [63:0]        req_data,
    output logic               mem_wr_valid,
    input  logic               mem_gnt,
    output logic [LINE_AW-1:0] mem_addr,
    output logic [7:0]         mem_be,
    output logic [63:0]        mem_wdata,
    output logic               done,
    output logic               err
);
    state_t               state_q, state_d;
    logic [LINE_AW-1:0]   line_q, line_nx;
    logic [15:0]          mask_q, mask_d;
    logic [127:0]         data_q, data_d;
    logic                 err_q, accept, beat0, beat1;
    logic                 unused;

    assign unused = ^{req_addr[63:LINE_AW+3]};

    store_lane_gen u_lane (
        .func3  (req_func3),
        .offset (req_addr[2:0]),
        .data   (req_data),
        .mask   (mask_d),
        .shifted(data_d)
    );

    assign req_ready = (state_q == IDLE) || (state_q == RETIRE);
    assign accept    = req_valid && req_ready;
    assign beat0     = state_q == BEAT0;
    assign beat1     = state_q == BEAT1;
    assign line_nx   = line_q + LINE_AW'(1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RETIRE: state_d = accept ? (req_func3[2] ? RETIRE : BEAT0)
                                           : IDLE;
            BEAT0:        state_d = !mem_gnt ? BEAT0 : (|mask_q[15:8] ? BEAT1 : RETIRE);
            BEAT1:        state_d = mem_gnt ? RETIRE : BEAT1;
            default:      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            line_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                line_q <= req_addr[LINE_AW+2:3];
                mask_q <= mask_d;
                data_q <= data_d;
                err_q  <= req_func3[2];
            end
        end
    end

    // Beat outputs decode only from registered state so dmem sees no req_* or gnt path.
    assign mem_wr_valid = beat0 || beat1;
    assign mem_addr     = beat0 ? line_q : (beat1 ? line_nx : '0);
    assign mem_be       = beat0 ? mask_q[7:0] : (beat1 ? mask_q[15:8] : 8'h00);
    assign mem_wdata    = beat0 ? data_q[63:0] : (beat1 ? data_q[127:64] : 64'h0);
    assign done         = (state_q == RETIRE) && !err_q;
    assign err          = (state_q == RETIRE) && err_q;
endmodule

// File: tb/tb_dmem_store_sequencer.sv
// tb_dmem_store_sequencer: directed and random stores checked against a byte-level model of the write beats.
module tb_dmem_store_sequencer;
    import dmem_pkg::*;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_func3 = '0;
    logic [63:0]   req_addr = '0;
    logic [63:0]   req_data = '0;
    logic          mem_wr_valid;
    logic          mem_gnt = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_be;
    logic [63:0]   mem_wdata;
    logic          done;
    logic          err;
    int            checks = 0;
    int            errors = 0;

    dmem_store_sequencer #(.LINE_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_func3(req_func3), .req_addr(req_addr), .req_data(req_data),
        .mem_wr_valid(mem_wr_valid), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte k of the store data lands in line (addr>>3)+beat at lane j when 8*beat+j-offset == k.
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic int nbeats(input logic [2:0] f3, input logic [63:0] addr);
        return (int'(addr[2:0]) + nbytes(f3) > 8) ? 2 : 1;
    endfunction

    function automatic logic [7:0] exp_be(input logic [2:0] f3, input logic [63:0] addr, input int b);
        logic [7:0] be = '0;
        for (int j = 0; j < 8; j++) begin
            int k = 8 * b + j - int'(addr[2:0]);
            be[j] = (k >= 0) && (k < nbytes(f3));
        end
        return be;
    endfunction

    function automatic logic [63:0] exp_wdata(input logic [63:0] addr, input logic [63:0] data, input int b);
        logic [63:0] w = '0;
        for (int j = 0; j < 8; j++) begin
            int k = 8 * b + j - int'(addr[2:0]);
            if (k >= 0 && k < 8) w[8*j +: 8] = data[8*k +: 8];
        end
        return w;
    endfunction

    function automatic logic [AW-1:0] exp_line(input logic [63:0] addr, input int b);
        return AW'((int'(addr[AW+2:3]) + b) % (1 << AW));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at edge+1 with req_ready expected high; leaves the DUT in its RETIRE cycle.
    task automatic do_store(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] data,
                            input int stall0, input int stall1);
        chk("ready_before", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_func3 = f3;
        req_addr  = addr;
        req_data  = data;
        mem_gnt   = 1'b0;
        tick();
        req_valid = 1'b0;
        if (f3[2]) begin
            chk("err_pulse", 64'(err), 64'd1);
            chk("err_no_done", 64'(done), 64'd0);
            chk("err_no_wr", 64'(mem_wr_valid), 64'd0);
            chk("err_ready", 64'(req_ready), 64'd1);
            return;
        end
        for (int b = 0; b < nbeats(f3, addr); b++) begin
            int stall = (b == 0) ? stall0 : stall1;
            for (int c = 0; c <= stall; c++) begin
                chk("wr_valid", 64'(mem_wr_valid), 64'd1);
                chk("line", 64'(mem_addr), 64'(exp_line(addr, b)));
                chk("be", 64'(mem_be), 64'(exp_be(f3, addr, b)));
                chk("wdata", mem_wdata, exp_wdata(addr, data, b));
                chk("busy_ready", 64'(req_ready), 64'd0);
                chk("busy_done", 64'({done, err}), 64'd0);
                mem_gnt = (c == stall);
                tick();
            end
        end
        mem_gnt = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        chk("retire_err", 64'(err), 64'd0);
        chk("retire_idle_bus", 64'({mem_wr_valid, mem_be}), 64'd0);
        chk("retire_ready", 64'(req_ready), 64'd1);
    endtask

    task automatic idle_cycle();
        tick();
        chk("idle_pulses", 64'({done, err, mem_wr_valid}), 64'd0);
        chk("idle_outputs", {mem_wdata[63:24], 3'b0, mem_addr, mem_be} , 64'd0);
        chk("idle_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        #12;
        chk("reset_ready", 64'(req_ready), 64'd1);
        chk("reset_outputs", 64'({mem_wr_valid, done, err, mem_be}), 64'd0);
        chk("reset_addr", 64'(mem_addr), 64'd0);
        rst_n = 1'b1;
        tick();
        do_store(F3_SD, 64'h0000_0040, 64'h1122_3344_5566_7788, 0, 0);
        idle_cycle();
        do_store(F3_SW, 64'h0000_0046, 64'hAABB_CCDD, 0, 0);
        idle_cycle();
        do_store(F3_SH, 64'h0000_FFFF, 64'hBEEF, 0, 0);
        idle_cycle();
        do_store(F3_SB, 64'h0000_0003, 64'h5A, 3, 0);
        idle_cycle();
        do_store(3'b100, 64'h0000_0010, 64'h1234, 0, 0);
        do_store(F3_SW, 64'h0000_0104, 64'hDEAD_BEEF, 0, 0);
        do_store(F3_SH, 64'h0000_0107, 64'hCAFE, 1, 2);
        idle_cycle();
        // Async reset while the first beat of a line-crossing store is on the bus.
        req_valid = 1'b1;
        req_func3 = F3_SW;
        req_addr  = 64'h0000_0046;
        req_data  = 64'hAABB_CCDD;
        mem_gnt   = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("rst_pre_beat0", 64'(mem_wr_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_wr", 64'({mem_wr_valid, done, err}), 64'd0);
        chk("rst_async_bus", 64'({mem_addr, mem_be}), 64'd0);
        chk("rst_async_ready", 64'(req_ready), 64'd1);
        mem_gnt = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) idle_cycle();
        mem_gnt = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic [2:0]  f3 = ($urandom_range(0, 9) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
            logic [63:0] a  = {32'($urandom), 32'($urandom)};
            logic [63:0] d  = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 7) == 0) a[15:3] = '1;
            do_store(f3, a, d, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
